// File: rtl/enigma_pkg.sv
// Shared Enigma types: letter index, PS/2 prefix bytes
// and the PS/2 frame FSM state encoding.
package enigma_pkg;

    typedef logic [5:0] letter_t;

    localparam letter_t LTR_A = 6'd0;
    localparam letter_t LTR_B = 6'd1;
    localparam letter_t LTR_C = 6'd2;
    localparam letter_t LTR_D = 6'd3;
    localparam letter_t LTR_E = 6'd4;
    localparam letter_t LTR_F = 6'd5;
    localparam letter_t LTR_G = 6'd6;
    localparam letter_t LTR_H = 6'd7;
    localparam letter_t LTR_I = 6'd8;
    localparam letter_t LTR_J = 6'd9;
    localparam letter_t LTR_K = 6'd10;
    localparam letter_t LTR_L = 6'd11;
    localparam letter_t LTR_M = 6'd12;
    localparam letter_t LTR_N = 6'd13;
    localparam letter_t LTR_O = 6'd14;
    localparam letter_t LTR_P = 6'd15;
    localparam letter_t LTR_Q = 6'd16;
    localparam letter_t LTR_R = 6'd17;
    localparam letter_t LTR_S = 6'd18;
    localparam letter_t LTR_T = 6'd19;
    localparam letter_t LTR_U = 6'd20;
    localparam letter_t LTR_V = 6'd21;
    localparam letter_t LTR_W = 6'd22;
    localparam letter_t LTR_X = 6'd23;
    localparam letter_t LTR_Y = 6'd24;
    localparam letter_t LTR_Z = 6'd25;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

endpackage

// File: rtl/ps2_input_filter.sv
// PS/2 line conditioning: synchronizers, clock
// stability filter and falling-edge pulse.
module ps2_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_filt,
    output logic data_sync,
    output logic fall
);

    logic [1:0]            clk_sync;
    logic [1:0]            dat_sync;
    logic [FILTER_LEN-1:0] clk_hist;
    logic [FILTER_LEN-1:0] dat_hist;

    // 2-FF synchronizers, idle-high after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // Sample history; data is delayed as much as the clock
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_hist <= '1;
            dat_hist <= '1;
        end else begin
            clk_hist <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
            dat_hist <= {dat_hist[FILTER_LEN-2:0], dat_sync[1]};
        end
    end

    // Filtered level changes only on a full run of equal samples
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt <= 1'b1;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_filt && (clk_hist == '0)) begin
                clk_filt <= 1'b0;
                fall     <= 1'b1;
            end else if (!clk_filt && (&clk_hist)) begin
                clk_filt <= 1'b1;
            end
        end
    end

    assign data_sync = dat_hist[FILTER_LEN-1];

endmodule

// File: rtl/ps2_letter_receiver.sv
// PS/2 set-2 frame receiver: turns letter make codes
// into 0..25 letter indices; drops breaks/extended keys.
module ps2_letter_receiver
    import enigma_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [5:0] letter_code,
    output logic       letter_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e  state;
    ps2_state_e  state_nx;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        par_bit;
    logic [TW-1:0] tmo_cnt;
    logic        ext_pend;
    logic        brk_pend;

    logic        clk_lvl_unused;
    logic        data;
    logic        fall;

    logic        tmo_hit;
    logic        fall_ok;
    logic        stop_fall;
    logic        good;
    logic        byte_ok;
    logic        is_ext;
    logic        is_brk;
    logic        valid_d;
    logic        err_d;
    logic        lut_hit;
    letter_t     lut_code;

    ps2_input_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filt (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_filt  (clk_lvl_unused),
        .data_sync (data),
        .fall      (fall)
    );

    assign tmo_hit = (state != ST_IDLE) &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign fall_ok = fall && !tmo_hit;

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Frame next-state logic; timeout overrides any edge
    always_comb begin
        state_nx = state;
        if (tmo_hit) begin
            state_nx = ST_IDLE;
        end else if (fall) begin
            unique case (state)
                ST_IDLE:   if (!data) state_nx = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_nx = ST_PARITY;
                ST_PARITY: state_nx = ST_STOP;
                ST_STOP:   state_nx = ST_IDLE;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    // Frame check and strobe decisions
    always_comb begin
        stop_fall = (state == ST_STOP) && fall_ok;
        good      = data && (^{shreg, par_bit});
        byte_ok   = stop_fall && good;
        is_ext    = (shreg == PS2_EXT);
        is_brk    = (shreg == PS2_BRK);
        valid_d   = byte_ok && !is_ext && !is_brk &&
                    !ext_pend && !brk_pend && lut_hit;
        err_d     = tmo_hit || (stop_fall && !good);
    end

    // Set-2 make code to letter index
    always_comb begin
        lut_hit  = 1'b1;
        lut_code = LTR_A;
        unique case (shreg)
            8'h1C: lut_code = LTR_A;
            8'h32: lut_code = LTR_B;
            8'h21: lut_code = LTR_C;
            8'h23: lut_code = LTR_D;
            8'h24: lut_code = LTR_E;
            8'h2B: lut_code = LTR_F;
            8'h34: lut_code = LTR_G;
            8'h33: lut_code = LTR_H;
            8'h43: lut_code = LTR_I;
            8'h3B: lut_code = LTR_J;
            8'h42: lut_code = LTR_K;
            8'h4B: lut_code = LTR_L;
            8'h3A: lut_code = LTR_M;
            8'h31: lut_code = LTR_N;
            8'h44: lut_code = LTR_O;
            8'h4D: lut_code = LTR_P;
            8'h15: lut_code = LTR_Q;
            8'h2D: lut_code = LTR_R;
            8'h1B: lut_code = LTR_S;
            8'h2C: lut_code = LTR_T;
            8'h3C: lut_code = LTR_U;
            8'h2A: lut_code = LTR_V;
            8'h1D: lut_code = LTR_W;
            8'h22: lut_code = LTR_X;
            8'h35: lut_code = LTR_Y;
            8'h1A: lut_code = LTR_Z;
            default: lut_hit = 1'b0;
        endcase
    end

    // Shift register, bit counter, parity capture
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
        end else if (tmo_hit) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (fall) begin
            unique case (state)
                ST_IDLE: begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                end
                ST_DATA: begin
                    shreg   <= {data, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                ST_PARITY: par_bit <= data;
                default: ;
            endcase
        end
    end

    // Inter-edge timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if ((state == ST_IDLE) || fall || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Prefix flags survive timeouts and bad frames
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (byte_ok) begin
            if (is_ext) begin
                ext_pend <= 1'b1;
            end else if (is_brk) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    // Registered output strobes; code holds between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            letter_code  <= '0;
            letter_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            letter_valid <= valid_d;
            frame_err    <= err_d;
            if (valid_d) letter_code <= lut_code;
        end
    end

endmodule

// File: tb/tb_ps2_letter_receiver.sv
// Self-checking bench for ps2_letter_receiver: bit-banged
// PS/2 frames, expected strobes kept in a scoreboard queue.
module tb_ps2_letter_receiver;

    localparam int FL  = 4;
    localparam int TMO = 300;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [5:0] letter_code;
    logic       letter_valid;
    logic       frame_err;

    typedef struct {
        logic [7:0] b;
        logic       par_flip;
        logic       stop_bad;
        logic       exp_let;
        logic       exp_err;
        logic [5:0] code;
    } vec_t;

    typedef struct {
        logic       err;
        logic [5:0] code;
    } exp_t;

    exp_t       exp_q[$];
    vec_t       vecs[$];
    int         tests = 0;
    int         fails = 0;
    logic [5:0] last_code = 6'd0;

    ps2_letter_receiver #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .letter_code  (letter_code),
        .letter_valid (letter_valid),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(H);
        ps2_clk = 1'b0;
        tick(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b,
                              input logic pf,
                              input logic sb);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ pf);
        ps2_bit(~sb);
        ps2_data = 1'b1;
        tick(2 * H);
    endtask

    task automatic push_exp(input logic err, input logic [5:0] code);
        exp_t e;
        e.err  = err;
        e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic settle_check(input string name);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s: pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        tests++;
        if (letter_code !== last_code) begin
            fails++;
            $display("FAIL %s hold: code=%0d required=%0d",
                     name, letter_code, last_code);
        end
    endtask

    initial begin
        vecs.push_back('{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0});
        vecs.push_back('{8'h1A, 1'b0, 1'b0, 1'b1, 1'b0, 6'd25});
        vecs.push_back('{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0});
        vecs.push_back('{8'h1A, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0});
        vecs.push_back('{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0});
        vecs.push_back('{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0});
        vecs.push_back('{8'h2D, 1'b0, 1'b0, 1'b1, 1'b0, 6'd17});
        vecs.push_back('{8'h24, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0});
        vecs.push_back('{8'h24, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0});
        vecs.push_back('{8'h24, 1'b0, 1'b0, 1'b1, 1'b0, 6'd4});
        vecs.push_back('{8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0});
        vecs.push_back('{8'h4D, 1'b0, 1'b0, 1'b1, 1'b0, 6'd15});
        vecs.push_back('{8'h4D, 1'b0, 1'b0, 1'b1, 1'b0, 6'd15});
        vecs.push_back('{8'h1D, 1'b0, 1'b0, 1'b1, 1'b0, 6'd22});
        vecs.push_back('{8'h35, 1'b0, 1'b0, 1'b1, 1'b0, 6'd24});

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (letter_valid && frame_err) begin
                        tests++;
                        fails++;
                        $display("FAIL both_high: valid=1 err=1 required one");
                    end else if (letter_valid || frame_err) begin
                        tests++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("FAIL unexpected: valid=%0b err=%0b code=%0d required none",
                                     letter_valid, frame_err, letter_code);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            if (e.err !== frame_err ||
                                (!e.err && letter_code !== e.code)) begin
                                fails++;
                                $display("FAIL strobe: err=%0b code=%0d required err=%0b code=%0d",
                                         frame_err, letter_code, e.err, e.code);
                            end
                            if (!e.err) last_code = e.code;
                        end
                    end
                end
            end
        join_none

        tick(5);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (letter_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_valid: got %0b required 0", letter_valid);
        end
        tests++;
        if (frame_err !== 1'b0) begin
            fails++;
            $display("FAIL rst_err: got %0b required 0", frame_err);
        end
        tests++;
        if (letter_code !== 6'd0) begin
            fails++;
            $display("FAIL rst_code: got %0d required 0", letter_code);
        end
        tick(10);

        foreach (vecs[i]) begin
            if (vecs[i].exp_let) push_exp(1'b0, vecs[i].code);
            if (vecs[i].exp_err) push_exp(1'b1, 6'd0);
            send_frame(vecs[i].b, vecs[i].par_flip, vecs[i].stop_bad);
            settle_check($sformatf("vec%0d", i));
        end

        push_exp(1'b1, 6'd0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        tick(TMO + 10);
        settle_check("timeout");
        push_exp(1'b0, 6'd16);
        send_frame(8'h15, 1'b0, 1'b0);
        settle_check("after_timeout");

        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(8'h43 >> i);
        @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        last_code = 6'd0;
        tick(2 * H);
        settle_check("reset_abort");
        push_exp(1'b0, 6'd8);
        send_frame(8'h43, 1'b0, 1'b0);
        settle_check("after_reset");

        send_frame(8'h29, 1'b0, 1'b0);
        settle_check("space");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_letter_receiver.md
# ps2_letter_receiver

Receives PS/2 keyboard frames (scan code set 2) and converts letter key presses into the 6-bit letter index (A=0 … Z=25) used throughout the Enigma datapath and by the 7-segment letter display. It sits at the input end of the design. It feeds one letter per key press to the rotor/plugboard pipeline, the same encoding the display decoder consumes. Key releases, extended codes and non-letter keys are filtered out here.

## Interface
- `FILTER_LEN`, 4: number of consecutive identical synchronized samples required before a `ps2_clk` level change is accepted.
- `TIMEOUT_CYCLES`, 100000: idle `clk` cycles inside a frame before the frame is abandoned (1 ms at 100 MHz).
- `clk`  in  1  system clock; sole clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock from the connector; asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the connector; asynchronous.
- `letter_code`  out  6  letter index 0–25; valid only while `letter_valid` is high.
- `letter_valid`  out  1  one-cycle strobe; one strobe per accepted letter make code.
- `frame_err`  out  1  one-cycle strobe on a parity error, stop-bit error or timeout.

## Operation
- **Input conditioning.**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
  - The synchronized `ps2_clk` then feeds a FILTER_LEN-sample stability filter.
  - A falling edge of the filtered clock produces a one-cycle `fall` pulse.
  - Data is sampled from synchronized `ps2_data` in the `fall` cycle.
- **Frame FSM states.**
  - IDLE: on `fall` with data=0 (start bit), go to DATA with bit count 0. On `fall` with data=1, stay in IDLE and flag nothing.
  - DATA: on each `fall`, shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, capture the parity bit, then go to STOP.
  - STOP: on `fall`, check the frame, then return to IDLE.
- **Frame check.** A frame is good when stop=1 and the 8 data bits plus parity hold an odd number of ones. Otherwise `frame_err` pulses and the byte is discarded.
- **Byte handling** (good frames only):
  - 0xE0: set `ext_pend`.
  - 0xF0: set `brk_pend`.
  - Any other byte with `brk_pend` or `ext_pend` set: discard the byte and clear both flags.
  - Any other byte with both flags clear: look it up in the letter table. On a hit, assert `letter_valid` with the index. On a miss, discard silently.
- **Letter table** (set 2 make codes):
  - A 1C, B 32, C 21, D 23, E 24, F 2B, G 34
  - H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31
  - O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C
  - V 2A, W 1D, X 22, Y 35, Z 1A
- **Typematic repeat.** Repeated make codes from a held key each produce a strobe; they are not suppressed.
- **Timeout.** In any state other than IDLE, a counter runs and is cleared on every `fall`. When it reaches TIMEOUT_CYCLES:
  - `frame_err` pulses.
  - The FSM returns to IDLE.
  - The shift register clears.
  - `brk_pend` and `ext_pend` are left unchanged.
- **Reset.**
  - Outputs: `letter_code`=0, `letter_valid`=0, `frame_err`=0.
  - Internal: FSM in IDLE, bit count 0, shift register 0, both pend flags 0, timeout counter 0.
  - Synchronizer and filter state is set to 1 (idle-high bus).
  - Reset mid-frame abandons the frame with no strobe.

## Timing
- Input latency: a raw `ps2_clk` falling edge produces `fall` after 2 synchronizer cycles plus FILTER_LEN filter cycles.
- Both lines are delayed equally, so data is sampled at the same relative point as the clock edge.
- Output latency: `letter_valid` and `frame_err` are registered. They assert in the cycle immediately after the `fall` that samples the stop bit (or after the timeout terminal count), for exactly one cycle.
- `letter_code` holds its last value between strobes.
- `letter_valid` and `frame_err` are never high in the same cycle.
- A `fall` arriving in the same cycle as the timeout terminal count: the timeout wins, and that `fall` is ignored.
- Minimum PS/2 clock period supported: 2·(FILTER_LEN+3) `clk` cycles.

## Structure
- **Shared package `enigma_pkg`:**
  - 6-bit letter index type and constants LTR_A..LTR_Z (0..25), shared with the display decoder.
  - PS/2 constants: PS2_EXT=0xE0, PS2_BRK=0xF0.
  - Frame FSM state enum.
- **Sub-module `ps2_input_filter`:** synchronizers, stability filter and `fall` pulse generation. It outputs the filtered clock level, synchronized data and `fall`.
- **Top module:** frame FSM, parity/stop check, timeout counter, prefix flags and the scan-code lookup (a combinational case inside the top module).

## Test plan
- Frame 0x1C, correct parity (parity bit 0, since 0x1C has three ones) → one `letter_valid` pulse with `letter_code`=0 (A); `frame_err` stays 0.
- Sequence 0x1A, then 0xF0, 0x1A → exactly one strobe, `letter_code`=25 (Z); the break pair produces nothing.
- Sequence 0xE0, 0x1C, then 0x2D → the 0x1C after 0xE0 is ignored; one strobe with `letter_code`=17 (R).
- Frame 0x24 with the parity bit flipped, then a frame 0x24 with stop=0 → two `frame_err` pulses and no `letter_valid`. A following good 0x24 → `letter_code`=4 (E).
- Start bit plus 3 data bits, then `ps2_clk` held high for TIMEOUT_CYCLES+10 → one `frame_err`, FSM back in IDLE. A following good frame 0x15 → `letter_code`=16 (Q).
- Assert `rst` for one cycle after the 5th data bit of a 0x43 frame, then send a full 0x43 → no strobe from the aborted frame; exactly one strobe with `letter_code`=8 (I). Also: a 0x29 (space) frame → no strobe, no error.
